truth_table_sweeper: RTL and testbench

//  Self-running exhaustive stimulus generator and checker for any N-input, 1-output combinational lab block.
//  - Drives every input vector 0 .. 2^N_IN-1 onto the DUT.
//  - Compares the DUT output against the expected truth table given as a parameter.
//  - Reports pass/fail, the mismatch count and the first failing vector.
//  - Sits beside the DUT in lab benches and on-board self-test tops; replaces hand-written stimulus lists.

---
 rtl/truth_table_sweeper.sv | 140 ++++++++++++++
 tb/tb_truth_table_sweeper.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive truth-table sweep and check of a 1-output combinational block
// Optional macro TTS_STOP_ON_ERR_EN: end the sweep at the first mismatch.
module truth_table_sweeper #(
  parameter int                 N_IN   = 4,
  parameter logic [2**N_IN-1:0] TRUTH  = '0,
  parameter int                 SETTLE = 1,
  parameter int                 ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dut_f,
  output logic [N_IN-1:0]  vec_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [N_IN-1:0]  first_err_vec,
  output logic             first_err_vld
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_CHECK, S_DONE} state_t;

  // With SETTLE=0 there is no hold phase, so every vector starts directly in CHECK.
  localparam state_t           VEC_ENTRY = (SETTLE > 0) ? S_HOLD : S_CHECK;
  localparam logic [3:0]       HOLD_LAST = 4'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [N_IN-1:0]  VEC_LAST  = '1;
  localparam logic [N_IN-1:0]  VEC_ONE   = 1;
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;
  localparam logic [ERR_W-1:0] ERR_ONE   = 1;

  state_t           state_q, state_d;
  logic [3:0]       hold_cnt_q, hold_cnt_d;
  logic [N_IN-1:0]  vec_out_q, vec_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [N_IN-1:0]  first_err_vec_q, first_err_vec_d;
  logic             first_err_vld_q, first_err_vld_d;

  logic             mismatch;
  logic             stop_early;

  always_comb begin
    state_d         = state_q;
    hold_cnt_d      = hold_cnt_q;
    vec_out_d       = vec_out_q;
    busy_d          = busy_q;
    done_d          = done_q;
    pass_d          = pass_q;
    err_count_d     = err_count_q;
    first_err_vec_d = first_err_vec_q;
    first_err_vld_d = first_err_vld_q;

    mismatch = (dut_f != TRUTH[vec_out_q]);
`ifdef TTS_STOP_ON_ERR_EN
    stop_early = mismatch;
`else
    stop_early = 1'b0;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d         = VEC_ENTRY;
          hold_cnt_d      = '0;
          vec_out_d       = '0;
          busy_d          = 1'b1;
          done_d          = 1'b0;
          pass_d          = 1'b0;
          err_count_d     = '0;
          first_err_vec_d = '0;
          first_err_vld_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = S_CHECK;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          if (err_count_q != ERR_MAX) err_count_d = err_count_q + ERR_ONE;
          if (!first_err_vld_q) begin
            first_err_vec_d = vec_out_q;
            first_err_vld_d = 1'b1;
          end
        end
        if (vec_out_q == VEC_LAST || stop_early) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_count_d == '0);
        end else begin
          state_d    = VEC_ENTRY;
          hold_cnt_d = '0;
          vec_out_d  = vec_out_q + VEC_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      hold_cnt_q      <= '0;
      vec_out_q       <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      err_count_q     <= '0;
      first_err_vec_q <= '0;
      first_err_vld_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      hold_cnt_q      <= hold_cnt_d;
      vec_out_q       <= vec_out_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
      err_count_q     <= err_count_d;
      first_err_vec_q <= first_err_vec_d;
      first_err_vld_q <= first_err_vld_d;
    end
  end

  assign vec_out       = vec_out_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_count_q;
  assign first_err_vec = first_err_vec_q;
  assign first_err_vld = first_err_vld_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - self-checking bench for truth_table_sweeper
// Honours TTS_STOP_ON_ERR_EN when the design is built with it.
module tb_truth_table_sweeper;

  localparam int          N_IN   = 4;
  localparam logic [15:0] TRUTH  = 16'hA5C3;
  localparam int          SETTLE = 1;
  localparam int          ERR_W  = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       dut_f;
  logic [3:0] vec_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic [3:0] first_err_vec;
  logic       first_err_vld;

  logic [15:0] truth_v = TRUTH;
  logic [15:0] fault   = '0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // The emulated lab block is the ideal function with selected vectors flipped.
  assign dut_f = truth_v[vec_out] ^ fault[vec_out];

  truth_table_sweeper #(
    .N_IN(N_IN), .TRUTH(TRUTH), .SETTLE(SETTLE), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .dut_f(dut_f),
    .vec_out(vec_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_vec(first_err_vec),
    .first_err_vld(first_err_vld)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sweep(input logic [15:0] mask, input bit poke_busy, input string tag);
    int  exp_errs, exp_first, exp_cycles, exp_vec, cycles;
    bit  exp_vld, seq_ok;
    // Reference: walk the table; each examined vector costs SETTLE+1 cycles.
    exp_errs = 0; exp_first = 0; exp_vld = 0; exp_vec = 15;
    exp_cycles = 16 * (SETTLE + 1);
    for (int k = 0; k < 16; k++) begin
      if (mask[k]) begin
        if (exp_errs < 255) exp_errs++;
        if (!exp_vld) begin
          exp_first = k;
          exp_vld   = 1;
`ifdef TTS_STOP_ON_ERR_EN
          exp_cycles = (k + 1) * (SETTLE + 1);
          exp_vec    = k;
          break;
`endif
        end
      end
    end

    fault = mask;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_start_busy"}, busy, 1);
    check({tag, "_start_clr"}, {done, pass, first_err_vld, err_count}, 0);

    cycles = 0;
    seq_ok = 1;
    while (busy && cycles < 400) begin
      if (vec_out !== 4'(cycles / (SETTLE + 1))) seq_ok = 0;
      start = (poke_busy && (cycles % 7 == 3)) ? 1'b1 : 1'b0;
      tick();
      cycles++;
    end
    start = 1'b0;

    check({tag, "_vec_seq"}, seq_ok, 1);
    check({tag, "_busy_cycles"}, cycles, exp_cycles);
    check({tag, "_done"}, done, 1);
    check({tag, "_pass"}, pass, (exp_errs == 0));
    check({tag, "_err_count"}, err_count, exp_errs);
    check({tag, "_first_vld"}, first_err_vld, exp_vld);
    if (exp_vld) check({tag, "_first_vec"}, first_err_vec, exp_first);
    check({tag, "_vec_final"}, vec_out, exp_vec);

    // DONE must hold its outputs while start stays low.
    tick(); tick();
    check({tag, "_done_hold"}, {done, busy, err_count}, {1'b1, 1'b0, 8'(exp_errs)});
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    start = 1'b0;
    tick(); tick();
    check("reset_outputs", {vec_out, busy, done, pass, err_count, first_err_vec, first_err_vld}, 0);
    rst = 1'b0;
    tick();
    check("idle_no_start", {busy, done}, 0);

    run_sweep(16'h0000, 0, "clean");
    run_sweep(16'h0200, 0, "vec9");
    run_sweep(TRUTH, 0, "tied0");
    run_sweep(16'h8000, 1, "last_poke");
    run_sweep(16'h0001, 0, "first");

    // Reset in the middle of a sweep.
    fault = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (vec_out != 4'd6 && guard < 100) begin
      tick();
      guard++;
    end
    check("reach_vec6", guard < 100, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_reset", {vec_out, busy, done, pass, err_count, first_err_vec, first_err_vld}, 0);
    tick();
    check("mid_reset_idle", busy, 0);

    // start and rst together: reset wins.
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    check("rst_over_start", {busy, vec_out}, 0);

    run_sweep(16'h0240, 0, "after_rst");

    for (int r = 0; r < 4; r++) begin
      logic [15:0] m;
      m = 16'($urandom & $urandom & $urandom);
      run_sweep(m, r[0], $sformatf("rand%0d", r));
    end
    run_sweep(16'($urandom), 1, "rand_dense");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
